// File: rtl/nes_video_pkg.sv
// Shared VGA timing constants, RGB type and the 2C02 colour table for the scanout path.
package nes_video_pkg;

  typedef logic [11:0] rgb12_t;

  localparam logic [9:0] H_ACTIVE     = 10'd640;
  localparam logic [9:0] H_FP         = 10'd16;
  localparam logic [9:0] H_SYNC       = 10'd96;
  localparam logic [9:0] H_BP         = 10'd48;
  localparam logic [9:0] H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam logic [9:0] H_SYNC_START = H_ACTIVE + H_FP;
  localparam logic [9:0] H_SYNC_END   = H_SYNC_START + H_SYNC;

  localparam logic [9:0] V_ACTIVE     = 10'd480;
  localparam logic [9:0] V_FP         = 10'd10;
  localparam logic [9:0] V_SYNC       = 10'd2;
  localparam logic [9:0] V_BP         = 10'd33;

  // 2C02 palette reduced to 4 bits per channel, index 0x00..0x3F
  localparam rgb12_t NES_PALETTE [0:63] = '{
    12'h777, 12'h218, 12'h00A, 12'h409, 12'h807, 12'hA01, 12'hA00, 12'h700,
    12'h420, 12'h040, 12'h050, 12'h031, 12'h135, 12'h000, 12'h000, 12'h000,
    12'hBBB, 12'h07E, 12'h23E, 12'h80F, 12'hB0B, 12'hE05, 12'hD20, 12'hC40,
    12'h870, 12'h090, 12'h0A0, 12'h093, 12'h088, 12'h000, 12'h000, 12'h000,
    12'hFFF, 12'h3BF, 12'h59F, 12'hA8F, 12'hF7F, 12'hF7B, 12'hF76, 12'hF93,
    12'hFB3, 12'h8D1, 12'h4D4, 12'h5F9, 12'h0ED, 12'h444, 12'h000, 12'h000,
    12'hFFF, 12'hAEF, 12'hCDF, 12'hDCF, 12'hFCF, 12'hFCD, 12'hFBB, 12'hFDA,
    12'hFEA, 12'hEFA, 12'hAFB, 12'hBFC, 12'h9FF, 12'hBBB, 12'h000, 12'h000
  };

endpackage

// File: rtl/nes_palette_rom.sv
// Registered NES colour lookup; forces black when the pixel is outside the picture.
module nes_palette_rom
  import nes_video_pkg::*;
(
  input  logic       sysclk,
  input  logic       reset,
  input  logic       pix_ce,
  input  logic       blank,
  input  logic [5:0] idx,
  output rgb12_t     rgb
);

  always_ff @(posedge sysclk) begin
    if (reset) begin
      rgb <= 12'h000;
    end else if (pix_ce) begin
      rgb <= blank ? 12'h000 : NES_PALETTE[idx];
    end
  end

endmodule

// File: rtl/nes_video_scanout.sv
// Frame-buffer reader and 640x480 VGA timing; each 256x240 source pixel shown 2x2, centred.
module nes_video_scanout
  import nes_video_pkg::*;
#(
  parameter logic [9:0] X_OFFSET = 10'd64,
  parameter logic       SYNC_POL = 1'b0,
  parameter logic [9:0] V_ACT    = V_ACTIVE,
  parameter logic [9:0] V_FRONT  = V_FP,
  parameter logic [9:0] V_PULSE  = V_SYNC,
  parameter logic [9:0] V_BACK   = V_BP
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic        pix_ce,
  output logic [15:0] fb_addr,
  output logic        fb_rd,
  input  logic [7:0]  fb_data,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_de,
  output rgb12_t      vga_rgb,
  output logic        frame_start
);

  localparam logic [9:0] V_TOT    = V_ACT + V_FRONT + V_PULSE + V_BACK;
  localparam logic [9:0] VS_START = V_ACT + V_FRONT;
  localparam logic [9:0] VS_END   = VS_START + V_PULSE;
  localparam logic [9:0] X_END    = X_OFFSET + 10'd512;

  logic [9:0] h_cnt, v_cnt, hx_p0;
  logic       in_pic_p0, de_p0, hs_p0, vs_p0;
  logic       vld_p1, de_p1, hs_p1, vs_p1;
  logic       unused_bits;

  // Stage 0: raster counters and read-address generation
  always_ff @(posedge sysclk) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_ce) begin
      if (h_cnt == H_TOTAL - 10'd1) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_TOT - 10'd1) ? '0 : v_cnt + 10'd1;
      end else begin
        h_cnt <= h_cnt + 10'd1;
      end
    end
  end

  always_comb begin
    hx_p0     = h_cnt - X_OFFSET;
    in_pic_p0 = (h_cnt >= X_OFFSET) && (h_cnt < X_END) && (v_cnt < V_ACT);
    de_p0     = (h_cnt < H_ACTIVE) && (v_cnt < V_ACT);
    hs_p0     = (h_cnt >= H_SYNC_START && h_cnt < H_SYNC_END) ? SYNC_POL : ~SYNC_POL;
    vs_p0     = (v_cnt >= VS_START && v_cnt < VS_END) ? SYNC_POL : ~SYNC_POL;
  end

  // Dropping bit 0 of both coordinates doubles pixels and re-reads each line twice
  assign fb_addr     = in_pic_p0 ? {v_cnt[8:1], hx_p0[8:1]} : 16'h0000;
  assign fb_rd       = in_pic_p0 & pix_ce & ~reset;
  assign frame_start = pix_ce & ~reset & (h_cnt == '0) & (v_cnt == '0);

  assign unused_bits = ^{fb_data[7:6], hx_p0[9], hx_p0[0], v_cnt[9], v_cnt[0]};

  // Stage 1: the RAM's own output register holds fb_data; controls wait alongside it
  always_ff @(posedge sysclk) begin
    if (reset) begin
      vld_p1 <= 1'b0;
      de_p1  <= 1'b0;
      hs_p1  <= ~SYNC_POL;
      vs_p1  <= ~SYNC_POL;
    end else if (pix_ce) begin
      vld_p1 <= in_pic_p0;
      de_p1  <= de_p0;
      hs_p1  <= hs_p0;
      vs_p1  <= vs_p0;
    end
  end

  // Stage 2: palette lookup and output registers
  nes_palette_rom u_palette (
    .sysclk (sysclk),
    .reset  (reset),
    .pix_ce (pix_ce),
    .blank  (~vld_p1),
    .idx    (fb_data[5:0]),
    .rgb    (vga_rgb)
  );

  always_ff @(posedge sysclk) begin
    if (reset) begin
      vga_de <= 1'b0;
      vga_hs <= ~SYNC_POL;
      vga_vs <= ~SYNC_POL;
    end else if (pix_ce) begin
      vga_de <= de_p1;
      vga_hs <= hs_p1;
      vga_vs <= vs_p1;
    end
  end

endmodule

// File: tb/tb_nes_video_scanout.sv
// Directed bench for nes_video_scanout, run with a shortened 15-line frame (8 visible lines).
module tb_nes_video_scanout;

  localparam int V_TOT = 15;

  typedef struct {
    int          h;
    int          v;
    logic        rd;
    logic [15:0] addr;
    logic        de;
    logic        hs;
    logic        vs;
    logic [11:0] rgb;
  } vec_t;

  logic        sysclk = 1'b0;
  logic        reset  = 1'b1;
  logic        pix_ce = 1'b1;
  logic [7:0]  fb_data = 8'h00;
  logic [15:0] fb_addr;
  logic        fb_rd, vga_hs, vga_vs, vga_de, frame_start;
  logic [11:0] vga_rgb;

  logic [7:0] fb_mem [0:65535];
  vec_t       tbl [33];

  int errors = 0, checks = 0;
  int cur_h = 0, cur_v = 0, t = 0;
  int rd_cnt = 0, hs_lo = 0, vs_lo = 0, de_hi = 0, fs_cnt = 0;
  bit gaps = 1'b0, stream_en = 1'b0;

  nes_video_scanout #(
    .V_ACT   (10'd8),
    .V_FRONT (10'd2),
    .V_PULSE (10'd2),
    .V_BACK  (10'd3)
  ) dut (
    .sysclk      (sysclk),
    .reset       (reset),
    .pix_ce      (pix_ce),
    .fb_addr     (fb_addr),
    .fb_rd       (fb_rd),
    .fb_data     (fb_data),
    .vga_hs      (vga_hs),
    .vga_vs      (vga_vs),
    .vga_de      (vga_de),
    .vga_rgb     (vga_rgb),
    .frame_start (frame_start)
  );

  always #5 sysclk = ~sysclk;

  // Frame-buffer read port: data appears one pixel tick after the strobe
  always @(posedge sysclk) begin
    if (fb_rd) fb_data <= fb_mem[fb_addr];
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input int h, input int v, input logic rd, input logic [15:0] addr,
                              input logic de, input logic hs, input logic vs, input logic [11:0] rgb);
    vec_t r;
    r.h = h; r.v = v; r.rd = rd; r.addr = addr;
    r.de = de; r.hs = hs; r.vs = vs; r.rgb = rgb;
    return r;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (h=%0d v=%0d)", name, act, exp, cur_h, cur_v);
    end
  endtask

  task automatic step();
    logic [9:0]  hx;
    logic        exp_rd;
    logic [15:0] exp_addr;
    @(posedge sysclk);
    #1;
    if (reset) begin
      cur_h = 0; cur_v = 0; t = 0;
    end else if (pix_ce) begin
      t++;
      if (cur_h == 799) begin
        cur_h = 0;
        cur_v = (cur_v == V_TOT - 1) ? 0 : cur_v + 1;
      end else begin
        cur_h++;
      end
    end
    pix_ce = gaps ? ($urandom_range(0, 3) == 0) : 1'b1;
    #1;
    if (!reset && pix_ce) begin
      if (t <= 11999 && fb_rd) rd_cnt++;
      if (t <= 12000 && frame_start) fs_cnt++;
      if (t >= 2 && t <= 12001) begin
        if (!vga_hs) hs_lo++;
        if (!vga_vs) vs_lo++;
        if (vga_de) de_hi++;
      end
      if (stream_en) begin
        hx       = 10'(cur_h - 64);
        exp_rd   = (cur_h >= 64) && (cur_h < 576) && (cur_v < 8);
        exp_addr = exp_rd ? {8'(cur_v >> 1), hx[8:1]} : 16'h0000;
        chk("stream_rd", {15'd0, fb_rd}, {15'd0, exp_rd});
        chk("stream_addr", fb_addr, exp_addr);
      end
    end
  endtask

  task automatic goto(input int h, input int v);
    int n;
    n = 0;
    while (!(cur_h == h && cur_v == v) && n < 60000) begin
      step();
      n++;
    end
    if (n >= 60000) begin
      checks++;
      errors++;
      $display("FAIL goto_timeout: stuck at h=%0d v=%0d, wanted h=%0d v=%0d", cur_h, cur_v, h, v);
    end
  endtask

  task automatic apply(input int i);
    goto(tbl[i].h, tbl[i].v);
    chk("fb_rd", {15'd0, fb_rd}, {15'd0, tbl[i].rd & pix_ce});
    chk("fb_addr", fb_addr, tbl[i].addr);
    chk("vga_de", {15'd0, vga_de}, {15'd0, tbl[i].de});
    chk("vga_hs", {15'd0, vga_hs}, {15'd0, tbl[i].hs});
    chk("vga_vs", {15'd0, vga_vs}, {15'd0, tbl[i].vs});
    chk("vga_rgb", {4'd0, vga_rgb}, {4'd0, tbl[i].rgb});
    chk("frame_start", {15'd0, frame_start}, 16'd0);
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) fb_mem[a] = 8'h16;
    fb_mem[0]      = 8'h30;
    fb_mem[1]      = 8'h0F;
    fb_mem[2]      = 8'hF0;
    fb_mem[3]      = 8'h21;
    fb_mem[256]    = 8'h11;
    fb_mem[16'h3FF] = 8'h2A;

    //            h    v  rd addr      de hs vs rgb   (outputs observed 2 ticks after their counter value)
    tbl[0]  = mk(  1,  0, 0, 16'h000, 0, 1, 1, 12'h000);
    tbl[1]  = mk(  2,  0, 0, 16'h000, 1, 1, 1, 12'h000);
    tbl[2]  = mk( 63,  0, 0, 16'h000, 1, 1, 1, 12'h000);
    tbl[3]  = mk( 64,  0, 1, 16'h000, 1, 1, 1, 12'h000);
    tbl[4]  = mk( 65,  0, 1, 16'h000, 1, 1, 1, 12'h000);
    tbl[5]  = mk( 66,  0, 1, 16'h001, 1, 1, 1, 12'hFFF);
    tbl[6]  = mk( 67,  0, 1, 16'h001, 1, 1, 1, 12'hFFF);
    tbl[7]  = mk( 68,  0, 1, 16'h002, 1, 1, 1, 12'h000);
    tbl[8]  = mk( 70,  0, 1, 16'h003, 1, 1, 1, 12'hFFF);
    tbl[9]  = mk( 72,  0, 1, 16'h004, 1, 1, 1, 12'h3BF);
    tbl[10] = mk(575,  0, 1, 16'h0FF, 1, 1, 1, 12'hD20);
    tbl[11] = mk(577,  0, 0, 16'h000, 1, 1, 1, 12'hD20);
    tbl[12] = mk(578,  0, 0, 16'h000, 1, 1, 1, 12'h000);
    tbl[13] = mk(641,  0, 0, 16'h000, 1, 1, 1, 12'h000);
    tbl[14] = mk(642,  0, 0, 16'h000, 0, 1, 1, 12'h000);
    tbl[15] = mk(657,  0, 0, 16'h000, 0, 1, 1, 12'h000);
    tbl[16] = mk(658,  0, 0, 16'h000, 0, 0, 1, 12'h000);
    tbl[17] = mk(753,  0, 0, 16'h000, 0, 0, 1, 12'h000);
    tbl[18] = mk(754,  0, 0, 16'h000, 0, 1, 1, 12'h000);
    tbl[19] = mk(  1,  1, 0, 16'h000, 0, 1, 1, 12'h000);
    tbl[20] = mk( 64,  1, 1, 16'h000, 1, 1, 1, 12'h000);
    tbl[21] = mk( 66,  1, 1, 16'h001, 1, 1, 1, 12'hFFF);
    tbl[22] = mk( 64,  2, 1, 16'h100, 1, 1, 1, 12'h000);
    tbl[23] = mk( 66,  2, 1, 16'h101, 1, 1, 1, 12'h07E);
    tbl[24] = mk(575,  7, 1, 16'h3FF, 1, 1, 1, 12'hD20);
    tbl[25] = mk(577,  7, 0, 16'h000, 1, 1, 1, 12'h4D4);
    tbl[26] = mk(578,  7, 0, 16'h000, 1, 1, 1, 12'h000);
    tbl[27] = mk(100,  8, 0, 16'h000, 0, 1, 1, 12'h000);
    tbl[28] = mk(  1, 10, 0, 16'h000, 0, 1, 1, 12'h000);
    tbl[29] = mk(  2, 10, 0, 16'h000, 0, 1, 0, 12'h000);
    tbl[30] = mk(  1, 12, 0, 16'h000, 0, 1, 0, 12'h000);
    tbl[31] = mk(  2, 12, 0, 16'h000, 0, 1, 1, 12'h000);
    tbl[32] = mk(100, 14, 0, 16'h000, 0, 1, 1, 12'h000);

    // Reset held with pix_ce high
    reset = 1'b1;
    repeat (5) step();
    chk("rst_hs", {15'd0, vga_hs}, 16'd1);
    chk("rst_vs", {15'd0, vga_vs}, 16'd1);
    chk("rst_de", {15'd0, vga_de}, 16'd0);
    chk("rst_rgb", {4'd0, vga_rgb}, 16'd0);
    chk("rst_fb_rd", {15'd0, fb_rd}, 16'd0);
    chk("rst_fb_addr", fb_addr, 16'd0);
    chk("rst_frame_start", {15'd0, frame_start}, 16'd0);

    reset = 1'b0;
    #1;
    chk("first_frame_start", {15'd0, frame_start}, 16'd1);

    // One full frame at pix_ce=1
    for (int i = 0; i < 33; i++) apply(i);
    goto(0, 0);
    chk("frame_ticks", 16'(t), 16'd12000);
    chk("frame_start_wrap", {15'd0, frame_start}, 16'd1);
    chk("frame_start_count", 16'(fs_cnt), 16'd1);
    step();
    chk("fb_rd_per_frame", 16'(rd_cnt), 16'd4096);
    chk("hs_low_per_frame", 16'(hs_lo), 16'd1440);
    chk("vs_low_per_frame", 16'(vs_lo), 16'd1600);
    chk("de_high_per_frame", 16'(de_hi), 16'd5120);

    // Sparse pixel enable: same picture sequence, address stream checked on every tick
    gaps  = 1'b1;
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    stream_en = 1'b1;
    for (int i = 0; i < 24; i++) apply(i);

    // Mid-frame reset restarts from a fresh frame
    goto(300, 3);
    reset = 1'b1;
    step();
    reset  = 1'b0;
    pix_ce = 1'b1;
    #1;
    chk("midrst_frame_start", {15'd0, frame_start}, 16'd1);
    chk("midrst_de", {15'd0, vga_de}, 16'd0);
    chk("midrst_hs", {15'd0, vga_hs}, 16'd1);
    chk("midrst_rgb", {4'd0, vga_rgb}, 16'd0);
    chk("midrst_fb_rd", {15'd0, fb_rd}, 16'd0);
    for (int i = 3; i < 10; i++) apply(i);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
